sca_weight_server: RTL and testbench
====================================

// Module: sca_weight_server
// PURPOSE
//  Responder for the SCA weight/index read interface. Accepts a sparse weight stream from the DMA:
//  per tile, one mask header word, then one value word per set mask bit. Decodes each tile to a
//  dense N_ROWSxN_COLS tile, stores it in tile memory, and serves sca weight_addr/index_addr reads
//  at fixed latency. Sits between the weight DMA and sca.
// PARAMETERS
//  DATA_W        16   weight word width; also the width of the mask header word
//  N_ROWS        4    transform-domain tile rows
//  N_COLS        4    transform-domain tile cols; N_ROWS*N_COLS <= DATA_W
//  TILE_DEPTH    256  tiles stored; power of 2, >= 2
//  WEIGHT_ADDR_W 12   weight read address width
//  INDEX_ADDR_W  10   index read address width; also index element width
// PORTS
//  clk         in   1                  clock
//  rst_n       in   1                  async active-low reset
//  flush       in   1                  sync clear: drop staging, tile count = 0
//  load_valid  in   1                  load word valid
//  load_ready  out  1                  load word accepted when valid&ready
//  load_data   in   DATA_W             header mask (bit k -> row k/N_COLS, col k%N_COLS) or signed value
//  load_last   in   1                  last word of layer
//  weight_addr in   WEIGHT_ADDR_W      tile read address for weights
//  index_addr  in   INDEX_ADDR_W       tile read address for indices
//  weight_data out  DATA_W [R][C]      dense signed weight tile
//  index_data  out  INDEX_ADDR_W [R][C] compressed ordinal of each nonzero element; 0 where masked
//  tiles_loaded out clog2(TILE_DEPTH)+1 committed tile count
//  full        out  1                  tiles_loaded == TILE_DEPTH
//  layer_done  out  1                  1-cycle pulse when the tile holding load_last commits
//  fmt_err     out  1                  sticky format error
// BEHAVIOUR
//  Reset: all outputs 0; load_ready 1; FSM in HDR; staging tile 0. Tile memory contents undefined;
//   unreadable until committed.
//  FSM HDR -> VALS -> COMMIT -> HDR.
//   HDR: accept the mask word and clear staging. popcount(mask) = 0 goes straight to COMMIT;
//    otherwise go to VALS, remaining = popcount.
//   VALS: each accepted word goes to the next set mask bit in ascending k order; that element's
//    index = ordinal 0..pop-1. When remaining reaches 0, go to COMMIT.
//   COMMIT: one cycle. Write staging to mem[tiles_loaded]; tiles_loaded += 1; layer_done pulses if
//    load_last was seen for this tile.
//  load_ready = (state != COMMIT) && !full. full blocks HDR acceptance only.
//  Any mask bits >= N_ROWS*N_COLS are ignored.
//  load_last not on the tile's final word: set fmt_err; the tile still decodes per its mask; the
//   layer ends at this tile's commit.
//  Read: weight_data/index_data are registered from mem[addr] one cycle after the address (latency 1).
//   addr >= tiles_loaded returns an all-zero tile. Reading the slot being committed in the same
//   cycle returns zero (old count rule).
//  flush: wins over load. Next cycle: FSM HDR, tiles_loaded 0, fmt_err 0, full 0.
//   Read outputs update normally.
//  Async reset mid-tile: the partial tile is discarded.
// CONFIGURATION
//  WSRV_RD_REG_EN defined: extra output register stage; read latency 2; sca address timing
//   shifts by 1 cycle.
//  WSRV_RD_REG_EN undefined: read latency 1.
// STRUCTURE
//  sca_pkg: DATA_W/N_ROWS/N_COLS defaults; tile typedef; MASK_W = N_ROWS*N_COLS; popcount
//   function; FSM state enum.
//  Sub-module sca_wsrv_unpack: HDR/VALS/COMMIT FSM and staging tile. The top level holds the tile
//   memory, read pipeline and counters.
// TESTING
//  Mask 0x0005 then values 7, -3: tile0 [0][0]=7, [0][2]=-3, rest 0; index [0][0]=0, [0][2]=1;
//   data valid 1 cycle after weight_addr=0.
//  Mask 0x0000 with load_last: commit after 1 word; zero tile; layer_done pulses once;
//   tiles_loaded=1.
//  TILE_DEPTH=4, load 4 tiles: full=1 and load_ready=0 after the 4th commit; flush gives
//   tiles_loaded=0, load_ready=1.
//  Mask 0x0007, load_last on the 2nd value: fmt_err=1; the 3rd value is still taken into [0][2];
//   layer_done at commit.
//  3 tiles loaded, weight_addr=5 and index_addr=3: all-zero outputs.
//  rst_n low mid-VALS: tiles_loaded unchanged from before, FSM HDR; the next header starts a clean tile.

Source files
------------

// File: rtl/sca_pkg.sv
// sca_pkg: shared defaults, tile types, FSM states and popcount for the
// SCA weight server. Build option: WSRV_RD_REG_EN (read latency 2).
package sca_pkg;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_N_ROWS       = 4;
  localparam int DEF_N_COLS       = 4;
  localparam int DEF_INDEX_ADDR_W = 10;
  localparam int MASK_W           = DEF_N_ROWS * DEF_N_COLS;

  typedef logic [DEF_N_ROWS-1:0][DEF_N_COLS-1:0][DEF_DATA_W-1:0]
    tile_t;
  typedef logic [DEF_N_ROWS-1:0][DEF_N_COLS-1:0][DEF_INDEX_ADDR_W-1:0]
    itile_t;

  typedef enum logic [1:0] {
    S_HDR,
    S_VALS,
    S_COMMIT
  } wsrv_state_e;

  function automatic logic [5:0] popcount(input logic [31:0] m);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, m[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sca_wsrv_unpack.sv
// sca_wsrv_unpack: HDR/VALS/COMMIT decoder that expands a sparse
// mask+values stream into the dense staging tile and its ordinals.
module sca_wsrv_unpack
  import sca_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int N_ROWS       = DEF_N_ROWS,
  parameter int N_COLS       = DEF_N_COLS,
  parameter int INDEX_ADDR_W = DEF_INDEX_ADDR_W,
  localparam int MW          = N_ROWS * N_COLS,
  localparam int KW          = (MW > 1) ? $clog2(MW) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_full,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_last,
  output logic                       o_commit,
  output logic                       o_last_seen,
  output logic                       o_fmt_err,
  output logic [MW*DATA_W-1:0]       o_stage_w,
  output logic [MW*INDEX_ADDR_W-1:0] o_stage_i
);

  wsrv_state_e r_state;
  wsrv_state_e w_next;

  logic [MW-1:0]                   r_rem;
  logic [INDEX_ADDR_W-1:0]         r_ord;
  logic [MW-1:0][DATA_W-1:0]       r_w;
  logic [MW-1:0][INDEX_ADDR_W-1:0] r_i;
  logic                            r_last;
  logic                            r_fmt;

  logic          w_acc;
  logic          w_empty;
  logic          w_final;
  logic [MW-1:0] w_mask;
  logic [MW-1:0] w_bit;
  logic [KW-1:0] w_k;

  // header bits beyond the tile are dropped here
  assign w_mask  = i_data[MW-1:0];
  assign w_empty = popcount(32'(w_mask)) == 6'd0;
  assign w_acc   = i_valid & o_ready & ~i_flush;
  assign w_final = (r_rem & ~w_bit) == '0;

  // lowest remaining mask bit receives the next value
  always_comb begin
    w_k   = '0;
    w_bit = '0;
    for (int k = MW - 1; k >= 0; k--) begin
      if (r_rem[k]) begin
        w_k      = KW'(k);
        w_bit    = '0;
        w_bit[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HDR;
    end else if (i_flush) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HDR: begin
        if (w_acc) w_next = w_empty ? S_COMMIT : S_VALS;
      end
      S_VALS: begin
        if (w_acc && w_final) w_next = S_COMMIT;
      end
      S_COMMIT: w_next = S_HDR;
      default:  w_next = S_HDR;
    endcase
  end

  always_comb begin
    o_ready  = 1'b0;
    o_commit = 1'b0;
    unique case (r_state)
      S_HDR:    o_ready  = ~i_full;
      S_VALS:   o_ready  = ~i_full;
      S_COMMIT: o_commit = 1'b1;
      default:  o_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_ord  <= '0;
      r_w    <= '0;
      r_i    <= '0;
      r_last <= 1'b0;
      r_fmt  <= 1'b0;
    end else if (i_flush) begin
      r_rem  <= '0;
      r_ord  <= '0;
      r_w    <= '0;
      r_i    <= '0;
      r_last <= 1'b0;
      r_fmt  <= 1'b0;
    end else if (w_acc && r_state == S_HDR) begin
      r_rem  <= w_mask;
      r_ord  <= '0;
      r_w    <= '0;
      r_i    <= '0;
      r_last <= i_last;
      if (i_last && !w_empty) r_fmt <= 1'b1;
    end else if (w_acc && r_state == S_VALS) begin
      r_w[w_k] <= i_data;
      r_i[w_k] <= r_ord;
      r_ord    <= r_ord + INDEX_ADDR_W'(1);
      r_rem    <= r_rem & ~w_bit;
      if (i_last) begin
        r_last <= 1'b1;
        if (!w_final) r_fmt <= 1'b1;
      end
    end
  end

  assign o_last_seen = r_last;
  assign o_fmt_err   = r_fmt;
  assign o_stage_w   = r_w;
  assign o_stage_i   = r_i;

endmodule

// File: rtl/sca_weight_server.sv
// sca_weight_server: sparse tile loader, tile memory and fixed-latency
// weight/index read ports. WSRV_RD_REG_EN adds a read output stage.
module sca_weight_server
  import sca_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int N_ROWS        = DEF_N_ROWS,
  parameter int N_COLS        = DEF_N_COLS,
  parameter int TILE_DEPTH    = 256,
  parameter int WEIGHT_ADDR_W = 12,
  parameter int INDEX_ADDR_W  = DEF_INDEX_ADDR_W,
  localparam int CNT_W        = $clog2(TILE_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_last,
  input  logic [WEIGHT_ADDR_W-1:0] weight_addr,
  input  logic [INDEX_ADDR_W-1:0]  index_addr,
  output logic [N_ROWS-1:0][N_COLS-1:0][DATA_W-1:0]
                                   weight_data,
  output logic [N_ROWS-1:0][N_COLS-1:0][INDEX_ADDR_W-1:0]
                                   index_data,
  output logic [CNT_W-1:0]         tiles_loaded,
  output logic                     full,
  output logic                     layer_done,
  output logic                     fmt_err
);

  localparam int MW = N_ROWS * N_COLS;
  localparam int AW = $clog2(TILE_DEPTH);
  localparam int WW = MW * DATA_W;
  localparam int IW = MW * INDEX_ADDR_W;

  logic          w_commit_st;
  logic          w_commit;
  logic          w_last_seen;
  logic [WW-1:0] w_stage_w;
  logic [IW-1:0] w_stage_i;
  logic          w_w_hit;
  logic          w_i_hit;

  logic [WW-1:0]    r_wmem [TILE_DEPTH];
  logic [IW-1:0]    r_imem [TILE_DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic             r_layer_done;
  logic [WW-1:0]    r_wd;
  logic [IW-1:0]    r_id;

  sca_wsrv_unpack #(
    .DATA_W      (DATA_W),
    .N_ROWS      (N_ROWS),
    .N_COLS      (N_COLS),
    .INDEX_ADDR_W(INDEX_ADDR_W)
  ) u_unpack (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_full     (full),
    .i_valid    (load_valid),
    .o_ready    (load_ready),
    .i_data     (load_data),
    .i_last     (load_last),
    .o_commit   (w_commit_st),
    .o_last_seen(w_last_seen),
    .o_fmt_err  (fmt_err),
    .o_stage_w  (w_stage_w),
    .o_stage_i  (w_stage_i)
  );

  assign w_commit     = w_commit_st & ~flush;
  assign full         = r_cnt == CNT_W'(TILE_DEPTH);
  assign tiles_loaded = r_cnt;
  assign layer_done   = r_layer_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_layer_done <= 1'b0;
    end else begin
      r_layer_done <= w_commit & w_last_seen;
      if (flush) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_wmem[r_cnt[AW-1:0]] <= w_stage_w;
      r_imem[r_cnt[AW-1:0]] <= w_stage_i;
    end
  end

  // the pre-commit count gates reads, so a slot reads zero on its commit cycle
  assign w_w_hit = 32'(weight_addr) < 32'(r_cnt);
  assign w_i_hit = 32'(index_addr) < 32'(r_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
      r_id <= '0;
    end else begin
      r_wd <= w_w_hit ? r_wmem[weight_addr[AW-1:0]] : '0;
      r_id <= w_i_hit ? r_imem[index_addr[AW-1:0]] : '0;
    end
  end

`ifdef WSRV_RD_REG_EN
  logic [WW-1:0] r_wd2;
  logic [IW-1:0] r_id2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd2 <= '0;
      r_id2 <= '0;
    end else begin
      r_wd2 <= r_wd;
      r_id2 <= r_id;
    end
  end

  assign weight_data = r_wd2;
  assign index_data  = r_id2;
`else
  assign weight_data = r_wd;
  assign index_data  = r_id;
`endif

endmodule

// File: tb/tb_sca_weight_server.sv
// tb_sca_weight_server: directed and random sparse tiles checked
// against an array-based tile model of the weight server.
module tb_sca_weight_server;

  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    flush;
  logic                    load_valid;
  logic                    load_ready;
  logic [15:0]             load_data;
  logic                    load_last;
  logic [11:0]             weight_addr;
  logic [9:0]              index_addr;
  logic [3:0][3:0][15:0]   weight_data;
  logic [3:0][3:0][9:0]    index_data;
  logic [2:0]              tiles_loaded;
  logic                    full;
  logic                    layer_done;
  logic                    fmt_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_w [DEPTH][16];
  logic [9:0]  m_i [DEPTH][16];
  int          m_cnt = 0;
  bit          m_fmt = 1'b0;

  sca_weight_server #(.TILE_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .weight_addr (weight_addr),
    .index_addr  (index_addr),
    .weight_data (weight_data),
    .index_data  (index_data),
    .tiles_loaded(tiles_loaded),
    .full        (full),
    .layer_done  (layer_done),
    .fmt_err     (fmt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_w(input int a);
    logic [255:0] r;
    r = '0;
    if (a < m_cnt)
      for (int k = 0; k < 16; k++) r[k*16 +: 16] = m_w[a[1:0]][k];
    return r;
  endfunction

  function automatic logic [255:0] exp_i(input int a);
    logic [255:0] r;
    r = '0;
    if (a < m_cnt)
      for (int k = 0; k < 16; k++) r[k*10 +: 10] = m_i[a[1:0]][k];
    return r;
  endfunction

  task automatic send_word(input logic [15:0] d, input bit last);
    int n;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    n = 0;
    while (!load_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("ready_timeout", 256'(0), 256'(1));
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic send_tile(input logic [15:0] mask, input int lastpos,
                           input logic [15:0] vals [16]);
    int pop, j, old;
    bit anylast, badlast;
    logic [15:0] ew [16];
    logic [9:0]  ei [16];
    pop = $countones(mask);
    j = 0;
    for (int k = 0; k < 16; k++) begin
      ew[k] = '0;
      ei[k] = '0;
      if (mask[k]) begin
        ew[k] = vals[j];
        ei[k] = 10'(j);
        j++;
      end
    end
    anylast = lastpos >= 0;
    badlast = anylast && lastpos != pop;
    send_word(mask, lastpos == 0);
    for (int v = 0; v < pop; v++) send_word(vals[v], lastpos == v + 1);
    old = m_cnt;
    weight_addr = 12'(old);
    index_addr  = 10'(old);
    chk("ld_early", 256'(layer_done), 256'(0));
    chk("rdy_commit", 256'(load_ready), 256'(0));
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      m_w[old][k] = ew[k];
      m_i[old][k] = ei[k];
    end
    m_cnt++;
    m_fmt = m_fmt | badlast;
    chk("tiles", 256'(tiles_loaded), 256'(m_cnt));
    chk("ld_pulse", 256'(layer_done), 256'(anylast));
    chk("fmt_err", 256'(fmt_err), 256'(m_fmt));
    chk("full", 256'(full), 256'(m_cnt == DEPTH));
    chk("ready", 256'(load_ready), 256'(m_cnt < DEPTH));
`ifndef WSRV_RD_REG_EN
    chk("rd_commit_w", 256'(weight_data), 256'(0));
    chk("rd_commit_i", 256'(index_data), 256'(0));
`endif
    @(negedge clk);
    chk("ld_once", 256'(layer_done), 256'(0));
`ifdef WSRV_RD_REG_EN
    chk("rd_commit_w", 256'(weight_data), 256'(0));
    chk("rd_commit_i", 256'(index_data), 256'(0));
`else
    chk("rd_new_w", 256'(weight_data), exp_w(old));
    chk("rd_new_i", 256'(index_data), exp_i(old));
`endif
  endtask

  task automatic rd_chk(input int wa, input int ia);
    weight_addr = 12'(wa);
    index_addr  = 10'(ia);
    @(negedge clk);
`ifdef WSRV_RD_REG_EN
    @(negedge clk);
`endif
    chk("rd_w", 256'(weight_data), exp_w(wa));
    chk("rd_i", 256'(index_data), exp_i(ia));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_cnt = 0;
    m_fmt = 1'b0;
    chk("fl_tiles", 256'(tiles_loaded), 256'(0));
    chk("fl_full", 256'(full), 256'(0));
    chk("fl_fmt", 256'(fmt_err), 256'(0));
    chk("fl_ready", 256'(load_ready), 256'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v [16];
    logic [15:0] mask;
    int pop, lp, r;

    rst_n       = 1'b0;
    flush       = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    weight_addr = '0;
    index_addr  = '0;
    for (int k = 0; k < 16; k++) v[k] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_tiles", 256'(tiles_loaded), 256'(0));
    chk("rst_full", 256'(full), 256'(0));
    chk("rst_ld", 256'(layer_done), 256'(0));
    chk("rst_fmt", 256'(fmt_err), 256'(0));
    chk("rst_ready", 256'(load_ready), 256'(1));
    chk("rst_w", 256'(weight_data), 256'(0));
    chk("rst_i", 256'(index_data), 256'(0));

    // partial tile interrupted by reset
    send_word(16'h0006, 1'b0);
    send_word(16'd99, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_tiles", 256'(tiles_loaded), 256'(0));
    chk("mid_rst_ready", 256'(load_ready), 256'(1));

    v[0] = 16'd7;
    v[1] = 16'hFFFD;
    send_tile(16'h0005, -1, v);
    rd_chk(0, 0);

    send_tile(16'h0000, 0, v);

    v[0] = 16'd1;
    v[1] = 16'd2;
    v[2] = 16'd3;
    send_tile(16'h0007, 2, v);

    rd_chk(5, 3);
    rd_chk(0, 2);
    rd_chk(1, 0);
    rd_chk(2, 1);

    for (int k = 0; k < 16; k++) v[k] = 16'(k * 3 + 100);
    send_tile(16'hF0F1, 8, v);
    rd_chk(3, 3);

    load_valid = 1'b1;
    load_data  = 16'h0001;
    repeat (3) begin
      @(negedge clk);
      chk("full_block", 256'(load_ready), 256'(0));
      chk("full_tiles", 256'(tiles_loaded), 256'(4));
    end
    load_valid = 1'b0;
    do_flush();
    rd_chk(0, 0);

    for (int t = 0; t < 60; t++) begin
      if (m_cnt == DEPTH || $urandom_range(0, 9) == 0) do_flush();
      r = $urandom_range(0, 7);
      if (r == 0) mask = 16'h0000;
      else if (r == 1) mask = 16'hFFFF;
      else mask = 16'($urandom);
      for (int k = 0; k < 16; k++) v[k] = 16'($urandom);
      pop = $countones(mask);
      r = $urandom_range(0, 3);
      if (r == 0) lp = -1;
      else if (r == 1) lp = $urandom_range(0, pop);
      else lp = pop;
      send_tile(mask, lp, v);
      rd_chk($urandom_range(0, 6), $urandom_range(0, 6));
      rd_chk($urandom_range(0, m_cnt - 1), $urandom_range(0, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
